// File: rtl/instr_dispatch_fsm_if.sv
// Bus between the dispatcher and its two neighbours: program memory (fetch side)
// and the execution-FSM bank (FSM_start/fsm_done command side).
interface instr_dispatch_fsm_if #(
    parameter int PC_W = 8
);
    logic            instr_rd_en;
    logic [PC_W-1:0] instr_addr;
    logic [19:0]     instr_data;
    logic            fsm_done;
    logic [3:0]      FSM_start;
    logic [3:0]      opcode;
    logic [5:0]      param1;
    logic [5:0]      param2;

    // Handshake: FSM_start is non-zero for exactly one cycle per issued command;
    // opcode/param1/param2 stay stable from that cycle until the active execution
    // FSM returns a one-cycle fsm_done pulse. instr_data is valid the cycle after
    // instr_rd_en is high for instr_addr.
    modport master (
        output instr_rd_en, instr_addr, FSM_start, opcode, param1, param2,
        input  instr_data, fsm_done
    );

    modport slave (
        input  instr_rd_en, instr_addr, FSM_start, opcode, param1, param2,
        output instr_data, fsm_done
    );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatcher: fetch, decode and issue commands to execution FSMs over the
// FSM_start/fsm_done handshake. Optional WAIT watchdog enabled by DISPATCH_TIMEOUT_EN.
module instr_dispatch_fsm #(
    parameter int PC_W        = 8,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [PC_W-1:0]     start_pc,
    instr_dispatch_fsm_if.master bus,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic            rd_en_q, rd_en_n;
    logic [3:0]      start_q, start_n;
    logic [3:0]      opcode_q, opcode_n;
    logic [5:0]      param1_q, param1_n;
    logic [5:0]      param2_q, param2_n;
    logic            busy_q, busy_n;
    logic            halted_q, halted_n;
    logic            error_q, error_n;

    logic [3:0] dec_fsm_id;
    logic [3:0] dec_opcode;
    logic [5:0] dec_param1;
    logic [5:0] dec_param2;

    assign dec_fsm_id = bus.instr_data[19:16];
    assign dec_opcode = bus.instr_data[15:12];
    assign dec_param1 = bus.instr_data[11:6];
    assign dec_param2 = bus.instr_data[5:0];

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        start_n  = 4'h0;
        opcode_n = opcode_q;
        param1_n = param1_q;
        param2_n = param2_q;
`ifdef DISPATCH_TIMEOUT_EN
        wait_cnt_n = wait_cnt;
`endif

        case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (run) begin
                    pc_n    = start_pc;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                case (dec_fsm_id)
                    4'h0: begin
                        pc_n    = pc + PC_W'(1);
                        state_n = S_FETCH;
                    end
                    4'h1, 4'h2, 4'h3: begin
                        start_n  = dec_fsm_id;
                        opcode_n = dec_opcode;
                        param1_n = dec_param1;
                        param2_n = dec_param2;
                        state_n  = S_ISSUE;
                    end
                    4'hF: begin
                        state_n = S_HALTED;
                    end
                    default: begin
                        state_n = S_ERROR;
                    end
                endcase
            end
            S_ISSUE: begin
                state_n = S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
            end
            S_WAIT: begin
                // fsm_done takes priority over the watchdog and over any run request
                if (bus.fsm_done) begin
                    pc_n    = pc + PC_W'(1);
                    state_n = S_FETCH;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n = S_ERROR;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Status and strobe registers are loaded from the next state so they line up with it
        rd_en_n  = (state_n == S_FETCH);
        busy_n   = (state_n == S_FETCH) || (state_n == S_DECODE) ||
                   (state_n == S_ISSUE) || (state_n == S_WAIT);
        halted_n = (state_n == S_HALTED);
        error_n  = (state_n == S_ERROR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            rd_en_q  <= 1'b0;
            start_q  <= 4'h0;
            opcode_q <= 4'h0;
            param1_q <= 6'h0;
            param2_q <= 6'h0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            rd_en_q  <= rd_en_n;
            start_q  <= start_n;
            opcode_q <= opcode_n;
            param1_q <= param1_n;
            param2_q <= param2_n;
            busy_q   <= busy_n;
            halted_q <= halted_n;
            error_q  <= error_n;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_n;
        end
    end
`endif

    assign bus.instr_rd_en = rd_en_q;
    assign bus.instr_addr  = pc;
    assign bus.FSM_start   = start_q;
    assign bus.opcode      = opcode_q;
    assign bus.param1      = param1_q;
    assign bus.param2      = param2_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
    assign error           = error_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed bench for instr_dispatch_fsm: program memory model, execution-side done
// driver, issue scoreboard and linear stimulus with immediate-assertion checks.
module tb_instr_dispatch_fsm;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    logic       clock;
    logic       reset;
    logic       run;
    logic [7:0] start_pc;
    logic       busy;
    logic       halted;
    logic       error;
    logic [2:0] state_dbg;

    logic [19:0] mem [256];
    logic [19:0] exp_q [$];
    logic        mon_en;
    int          tests;
    int          fails;

    instr_dispatch_fsm_if #(.PC_W(8)) bus ();

    instr_dispatch_fsm #(.PC_W(8), .TIMEOUT_CYC(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .start_pc (start_pc),
        .bus      (bus),
        .busy     (busy),
        .halted   (halted),
        .error    (error),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program memory: one-cycle read latency
    always_ff @(posedge clock) begin
        if (bus.instr_rd_en) bus.instr_data <= mem[bus.instr_addr];
    end

    function automatic logic [19:0] enc(input logic [3:0] id, input logic [3:0] op,
                                        input logic [5:0] p1, input logic [5:0] p2);
        return {id, op, p1, p2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard: every non-zero FSM_start cycle must match the next expected issue record
    always @(negedge clock) begin
        if (mon_en && (bus.FSM_start !== 4'h0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {28'h0, bus.FSM_start}, 32'h0);
            end else begin
                check("issue", {12'h0, bus.FSM_start, bus.opcode, bus.param1, bus.param2},
                      {12'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        tests        = 0;
        fails        = 0;
        mon_en       = 1'b0;
        reset        = 1'b1;
        run          = 1'b0;
        start_pc     = 8'h00;
        bus.fsm_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = enc(4'hF, 4'h0, 6'h0, 6'h0);

        // Reset state
        step(2);
        mon_en = 1'b1;
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_outs", {bus.instr_rd_en, busy, halted, error, bus.FSM_start}, 0);
        check("rst_ops", {bus.opcode, bus.param1, bus.param2, bus.instr_addr}, 0);
        reset = 1'b0;
        step(1);
        check("idle_hold", state_dbg, ST_IDLE);

        // Issue timing, done during ISSUE ignored, done after 11 cycles
        mem[8'h00] = enc(4'h2, 4'h3, 6'd5, 6'd2);
        mem[8'h01] = enc(4'hF, 4'h0, 6'd0, 6'd0);
        exp_q.push_back(enc(4'h2, 4'h3, 6'd5, 6'd2));
        start_pc = 8'h00;
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("t1_rd_en_c1", {bus.instr_rd_en, bus.instr_addr, busy}, {1'b1, 8'h00, 1'b1});
        check("t1_fetch_st", state_dbg, ST_FETCH);
        step(1);
        check("t1_decode_c2", {state_dbg, bus.instr_rd_en, bus.FSM_start}, {ST_DECODE, 1'b0, 4'h0});
        step(1);
        check("t1_issue_c3", {bus.FSM_start, bus.opcode, bus.param1, bus.param2},
              {4'h2, 4'h3, 6'd5, 6'd2});
        bus.fsm_done = 1'b1;
        step(1);
        bus.fsm_done = 1'b0;
        check("t1_start_clr_c4", bus.FSM_start, 4'h0);
        check("t2_done_in_issue_ignored", state_dbg, ST_WAIT);
        step(10);
        check("t2_wait_c14", {state_dbg, busy}, {ST_WAIT, 1'b1});
        check("t2_ops_held", {bus.opcode, bus.param1, bus.param2}, {4'h3, 6'd5, 6'd2});
        bus.fsm_done = 1'b1;
        step(1);
        bus.fsm_done = 1'b0;
        check("t2_refetch", {state_dbg, bus.instr_rd_en, bus.instr_addr}, {ST_FETCH, 1'b1, 8'h01});
        step(2);
        check("t2_halted", {halted, busy, error, bus.instr_addr}, {1'b1, 1'b0, 1'b0, 8'h01});
        check("t2_ops_kept", {bus.opcode, bus.param1, bus.param2}, {4'h3, 6'd5, 6'd2});

        // NOP / load / halt program; run+done in the same WAIT cycle
        mem[8'h00] = enc(4'h0, 4'h0, 6'd0, 6'd0);
        mem[8'h01] = enc(4'h1, 4'h0, 6'd1, 6'd0);
        mem[8'h02] = enc(4'hF, 4'h0, 6'd0, 6'd0);
        exp_q.push_back(enc(4'h1, 4'h0, 6'd1, 6'd0));
        start_pc = 8'h00;
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("t3_restart", {halted, busy}, {1'b0, 1'b1});
        step(2);
        check("t3_nop_fetch", {state_dbg, bus.instr_rd_en, bus.instr_addr}, {ST_FETCH, 1'b1, 8'h01});
        step(2);
        check("t3_issue", bus.FSM_start, 4'h1);
        step(1);
        check("t3_wait", state_dbg, ST_WAIT);
        start_pc     = 8'h40;
        run          = 1'b1;
        bus.fsm_done = 1'b1;
        step(1);
        run          = 1'b0;
        bus.fsm_done = 1'b0;
        check("t3_done_wins", {state_dbg, bus.instr_addr}, {ST_FETCH, 8'h02});
        step(2);
        check("t3_halt_pc2", {halted, busy, bus.instr_addr}, {1'b1, 1'b0, 8'h02});
        check("t3_ops_kept", {bus.opcode, bus.param1, bus.param2}, {4'h0, 6'd1, 6'd0});

        // Illegal fsm_id
        mem[8'h20] = enc(4'h5, 4'h7, 6'd3, 6'd3);
        start_pc = 8'h20;
        run = 1'b1;
        step(1);
        run = 1'b0;
        step(2);
        check("t4_error", {error, busy, halted, state_dbg}, {1'b1, 1'b0, 1'b0, ST_ERROR});
        check("t4_err_pc", bus.instr_addr, 8'h20);
        step(3);
        check("t4_error_hold", {error, bus.param1}, {1'b1, 6'd1});
        mem[8'h30] = enc(4'hF, 4'h0, 6'd0, 6'd0);
        start_pc = 8'h30;
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("t4_run_clears", {error, busy, bus.instr_addr}, {1'b0, 1'b1, 8'h30});
        step(2);
        check("t4_halt_again", halted, 1'b1);

        // WAIT without fsm_done
        mem[8'h40] = enc(4'h3, 4'hA, 6'h3F, 6'h15);
        mem[8'h41] = enc(4'hF, 4'h0, 6'd0, 6'd0);
        exp_q.push_back(enc(4'h3, 4'hA, 6'h3F, 6'h15));
        start_pc = 8'h40;
        run = 1'b1;
        step(1);
        run = 1'b0;
        step(2);
        check("t5_issue", bus.FSM_start, 4'h3);
`ifdef DISPATCH_TIMEOUT_EN
        step(32);
        check("t5_wait_last", {state_dbg, error}, {ST_WAIT, 1'b0});
        step(1);
        check("t5_timeout", {error, busy, state_dbg, bus.instr_addr}, {1'b1, 1'b0, ST_ERROR, 8'h40});
`else
        step(1000);
        check("t5_still_wait", {state_dbg, busy, error}, {ST_WAIT, 1'b1, 1'b0});
        bus.fsm_done = 1'b1;
        step(1);
        bus.fsm_done = 1'b0;
        check("t5_release", {state_dbg, bus.instr_addr}, {ST_FETCH, 8'h41});
        step(2);
        check("t5_halted", halted, 1'b1);
`endif

        // pc wrap, then reset in WAIT
        mem[8'hFF] = enc(4'h0, 4'h0, 6'd0, 6'd0);
        mem[8'h00] = enc(4'h2, 4'h1, 6'd2, 6'd3);
        exp_q.push_back(enc(4'h2, 4'h1, 6'd2, 6'd3));
        start_pc = 8'hFF;
        run = 1'b1;
        step(1);
        run = 1'b0;
        check("t6_fetch_ff", {bus.instr_rd_en, bus.instr_addr}, {1'b1, 8'hFF});
        step(2);
        check("t6_wrap", {state_dbg, bus.instr_rd_en, bus.instr_addr}, {ST_FETCH, 1'b1, 8'h00});
        step(2);
        check("t6_issue", bus.FSM_start, 4'h2);
        step(1);
        check("t6_wait", state_dbg, ST_WAIT);
        reset = 1'b1;
        step(1);
        check("t6_rst_state", state_dbg, ST_IDLE);
        check("t6_rst_outs", {bus.instr_rd_en, busy, halted, error, bus.FSM_start}, 0);
        check("t6_rst_ops", {bus.opcode, bus.param1, bus.param2, bus.instr_addr}, 0);
        reset = 1'b0;
        step(2);

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
